// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and writeback-source select encodings.
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/mux_pipe_stage_if.sv
// Handshake/data bundle for mux_pipe_stage; slave is the stage view, master the surrounding pipeline view.
interface mux_pipe_stage_if
    import mips_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int NUM_IN = 2
) ();

    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );

endinterface

// File: rtl/mux_nto1.sv
// Combinational N-to-1 select; selects outside 0..NUM_IN-1 fall back to input 0 and raise sel_err.
module mux_nto1 #(
    parameter int  WIDTH  = 32,
    parameter int  NUM_IN = 2,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    sel_err
);

    always_comb begin
        out_data = in_data[WIDTH-1:0];
        sel_err  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                out_data = in_data[i*WIDTH +: WIDTH];
                sel_err  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_pipe_stage.sv
// Registered N-to-1 mux pipeline stage with valid/ready, flush and bad-select pulse.
// Define MUX_PIPE_SKID_EN to add a one-entry skid buffer and register in_ready.
module mux_pipe_stage
    import mips_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int NUM_IN = 2
) (
    input logic             clk,
    input logic             rst_n,
    mux_pipe_stage_if.slave bus
);

    logic [WIDTH-1:0] mux_data;
    logic             mux_err;
    logic             accept;

    mux_nto1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_mux (
        .in_data  (bus.in_data),
        .sel      (bus.sel),
        .out_data (mux_data),
        .sel_err  (mux_err)
    );

`ifdef MUX_PIPE_SKID_EN
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             skid_err;

    assign bus.in_ready = !skid_valid;
    assign accept       = bus.in_valid && !skid_valid && !bus.flush;

    // skid entry refills the output before any newer word, keeping order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.sel_err   <= 1'b0;
            skid_data     <= '0;
            skid_valid    <= 1'b0;
            skid_err      <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
            bus.sel_err   <= 1'b0;
            skid_valid    <= 1'b0;
        end else if (!bus.out_valid || bus.out_ready) begin
            if (skid_valid) begin
                bus.out_data  <= skid_data;
                bus.out_valid <= 1'b1;
                bus.sel_err   <= skid_err;
                skid_valid    <= 1'b0;
            end else if (accept) begin
                bus.out_data  <= mux_data;
                bus.out_valid <= 1'b1;
                bus.sel_err   <= mux_err;
            end else begin
                bus.out_valid <= 1'b0;
                bus.sel_err   <= 1'b0;
            end
        end else begin
            bus.sel_err <= 1'b0;
            if (accept) begin
                skid_data  <= mux_data;
                skid_err   <= mux_err;
                skid_valid <= 1'b1;
            end
        end
    end
`else
    logic drain;

    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = bus.out_valid && bus.out_ready;

    // data only loads on accept, so an undriven sel while idle never reaches state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.sel_err   <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
            bus.sel_err   <= 1'b0;
        end else if (accept) begin
            bus.out_data  <= mux_data;
            bus.out_valid <= 1'b1;
            bus.sel_err   <= mux_err;
        end else begin
            bus.sel_err <= 1'b0;
            if (drain) bus.out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Randomised + directed bench for mux_pipe_stage, two configurations (32x4 and 5x3) against a FIFO-level model.
module tb_mux_pipe_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_pipe_stage_if #(.WIDTH(WORD_W),     .NUM_IN(4)) b4 ();
    mux_pipe_stage_if #(.WIDTH(REG_ADDR_W), .NUM_IN(3)) b3 ();

    mux_pipe_stage #(.WIDTH(WORD_W),     .NUM_IN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    mux_pipe_stage #(.WIDTH(REG_ADDR_W), .NUM_IN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    // model: words in flight as a small queue, front is what the output shows
    int          cnt   [2];
    logic [31:0] qd    [2][2];
    logic        qe    [2][2];
    logic        fresh [2];
    logic [31:0] last  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int   nin(int k);   return k == 0 ? 4 : 3; endfunction
    function automatic logic iv(int k);    return k == 0 ? b4.in_valid  : b3.in_valid;  endfunction
    function automatic logic fl(int k);    return k == 0 ? b4.flush     : b3.flush;     endfunction
    function automatic logic ordy(int k);  return k == 0 ? b4.out_ready : b3.out_ready; endfunction
    function automatic logic drdy(int k);  return k == 0 ? b4.in_ready  : b3.in_ready;  endfunction
    function automatic logic dval(int k);  return k == 0 ? b4.out_valid : b3.out_valid; endfunction
    function automatic logic derr(int k);  return k == 0 ? b4.sel_err   : b3.sel_err;   endfunction
    function automatic int   selv(int k);  return k == 0 ? int'(b4.sel) : int'(b3.sel); endfunction
    function automatic logic [31:0] ddat(int k);
        return k == 0 ? b4.out_data : 32'(b3.out_data);
    endfunction
    function automatic logic [31:0] word(int k, int i);
        return k == 0 ? b4.in_data[i*32 +: 32] : 32'(b3.in_data[i*5 +: 5]);
    endfunction

    function automatic logic mrdy(int k);
`ifdef MUX_PIPE_SKID_EN
        return cnt[k] < 2;
`else
        return (cnt[k] == 0 || ordy(k)) && !fl(k);
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; fresh[k] = 1'b0; last[k] = '0;
            qd[k][0] = '0; qd[k][1] = '0; qe[k][0] = 1'b0; qe[k][1] = 1'b0;
        end
    endtask

    task automatic check_outs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_valid%0d", k), 32'(dval(k)), 32'(cnt[k] > 0));
            chk($sformatf("out_data%0d", k), ddat(k), last[k]);
            chk($sformatf("sel_err%0d", k), 32'(derr(k)), 32'(fresh[k] && qe[k][0]));
        end
    endtask

    // called just after a falling edge with inputs already driven
    task automatic step();
        logic        acc [2];
        logic [31:0] nd  [2];
        logic        ne  [2];
        logic        pop, was_empty;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("in_ready%0d", k), 32'(drdy(k)), 32'(mrdy(k)));
            acc[k] = iv(k) && mrdy(k) && !fl(k);
            nd[k]  = '0;
            ne[k]  = 1'b0;
            if (acc[k]) begin
                ne[k] = selv(k) >= nin(k);
                nd[k] = word(k, ne[k] ? 0 : selv(k));
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (fl(k)) begin
                cnt[k]   = 0;
                fresh[k] = 1'b0;
            end else begin
                was_empty = cnt[k] == 0;
                pop       = cnt[k] > 0 && ordy(k);
                if (pop) begin
                    qd[k][0] = qd[k][1];
                    qe[k][0] = qe[k][1];
                    cnt[k]--;
                end
                if (acc[k]) begin
                    qd[k][cnt[k]] = nd[k];
                    qe[k][cnt[k]] = ne[k];
                    cnt[k]++;
                end
                fresh[k] = cnt[k] > 0 && (pop || was_empty);
                if (cnt[k] > 0) last[k] = qd[k][0];
            end
        end
        #1;
        check_outs();
        @(negedge clk);
    endtask

    task automatic idle_all();
        b4.in_valid = 1'b0; b4.flush = 1'b0; b4.out_ready = 1'b1; b4.sel = '0; b4.in_data = '0;
        b3.in_valid = 1'b0; b3.flush = 1'b0; b3.out_ready = 1'b1; b3.sel = '0; b3.in_data = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        model_reset();
        #2;
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;

        // single word, sel=2
        b4.in_data  = {32'hD, 32'hC, 32'hB, 32'hA};
        b4.sel      = 2'd2;
        b4.in_valid = 1'b1;
        step();
        chk("t1_data", b4.out_data, 32'hC);
        chk("t1_valid", 32'(b4.out_valid), 32'd1);

        // back-to-back stream
        for (int s = 0; s < 4; s++) begin
            b4.sel = 2'(s);
            step();
            chk("stream_data", b4.out_data, 32'hA + 32'(s));
        end

        // stall three cycles while upstream keeps offering, then release
        b4.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 4; i++) b4.in_data[i*32 +: 32] = $urandom;
            b4.sel = 2'(s + 1);
            step();
        end
        b4.out_ready = 1'b1;
        b4.in_valid  = 1'b0;
        for (int s = 0; s < 3; s++) step();

        // out-of-range select on the 3-input instance
        b3.in_data  = {5'd3, 5'd9, 5'd7};
        b3.sel      = 2'd3;
        b3.in_valid = 1'b1;
        step();
        chk("oor_data", 32'(b3.out_data), 32'd7);
        chk("oor_err", 32'(b3.sel_err), 32'd1);
        b3.in_valid = 1'b0;
        step();
        chk("oor_err_clr", 32'(b3.sel_err), 32'd0);

        // flush with a word offered: dropped, then normal accept
        b4.in_valid = 1'b1; b4.flush = 1'b1; b4.sel = 2'd1;
        b3.in_valid = 1'b1; b3.flush = 1'b1; b3.sel = 2'd2;
        step();
        chk("flush_valid", 32'(b4.out_valid), 32'd0);
        b4.flush = 1'b0; b3.flush = 1'b0;
        step();
        b4.in_valid = 1'b0; b3.in_valid = 1'b0;
        step();

        // random traffic
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < 4; i++) b4.in_data[i*32 +: 32] = $urandom;
            b3.in_data   = 15'($urandom);
            b4.in_valid  = ($urandom % 4) != 0;
            b3.in_valid  = ($urandom % 4) != 0;
            b4.sel       = b4.in_valid ? 2'($urandom) : 2'bx;
            b3.sel       = b3.in_valid ? 2'($urandom) : 2'bx;
            b4.out_ready = ($urandom % 3) != 0;
            b3.out_ready = ($urandom % 3) != 0;
            b4.flush     = ($urandom % 16) == 0;
            b3.flush     = ($urandom % 16) == 0;
            step();
        end

        // reset in the middle of a stall
        idle_all();
        b4.in_data = {32'h44, 32'h33, 32'h22, 32'h11};
        b4.in_valid = 1'b1; b4.out_ready = 1'b0; b4.sel = 2'd3;
        b3.in_data = {5'd1, 5'd2, 5'd3};
        b3.in_valid = 1'b1; b3.out_ready = 1'b0; b3.sel = 2'd3;
        step();
        step();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 32'(b4.out_valid), 32'd0);
        chk("rst_data", b4.out_data, 32'd0);
        chk("rst_err3", 32'(b3.sel_err), 32'd0);
        check_outs();
        #2;
        rst_n = 1'b1;
        b4.out_ready = 1'b1; b4.sel = 2'd1;
        b3.out_ready = 1'b1; b3.sel = 2'd1;
        step();
        chk("post_rst_data", b4.out_data, 32'h22);
        b4.in_valid = 1'b0; b3.in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_pipe_stage.md
Name: mux_pipe_stage

Overview:
- Parametrised N-to-1 datapath multiplexer with a registered output stage and valid/ready handshake.
- Generalises the fixed 5-bit and 32-bit 2:1 MIPS datapath muxes in width and input count.
- Adds pipeline-register behaviour: stall, flush and out-of-range select detection.
- Sits between MIPS pipeline stages, e.g. writeback-source select into WB, or register-destination select into the EX/MEM boundary.

Parameters:
- WIDTH, 32, data width per input; 5 for register addresses.
- NUM_IN, 2, number of inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  in  SEL_W  binary select, sampled with in_data.
- in_valid  in  1  upstream has data.
- in_ready  out  1  stage can accept data this cycle.
- flush  in  1  synchronous pipeline flush.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts data.
- sel_err  out  1  one-cycle pulse: the last accepted sel was >= NUM_IN.

Behaviour:
- Reset (rst_n low, asynchronous): out_data=0, out_valid=0, sel_err=0. Takes effect immediately, mid-transfer included. First accept is possible on the first rising edge after rst_n deasserts.
- in_ready = !out_valid || out_ready. This is a combinational path from out_ready. Forced 0 while flush=1.
- Accept when in_valid && in_ready. Next edge: out_data <= in_data[sel*WIDTH +: WIDTH], out_valid <= 1. Latency is 1 cycle.
- Throughput: 1 word/cycle when out_ready is held high.
- Drain with no accept (out_valid && out_ready && !accept): out_valid <= 0 and out_data holds its value.
- Stall (out_valid && !out_ready): out_data and out_valid held stable, no new accept.
- sel >= NUM_IN (non-power-of-2 NUM_IN only): selects input 0. sel_err=1 for exactly the cycle the resulting word first appears on out_data, 0 otherwise.
- flush=1: next edge out_valid <= 0 and sel_err <= 0, out_data unchanged. Flush wins over a simultaneous accept or drain.
- Simultaneous accept and drain: the new word replaces the old one and out_valid stays 1.
- X on sel while in_valid=0 must not propagate into state.

Optional Feature:
- Macro: MUX_PIPE_SKID_EN.
- Defined:
  - Adds a one-entry skid buffer, so in_ready is a registered signal equal to !skid_valid.
  - Removes the combinational out_ready→in_ready path.
  - When the output register is stalled and a word is accepted, the word goes to the skid entry. The skid entry moves to the output on the next drain.
  - Order is preserved. Flush clears both entries. Latency is 1 cycle when the pipe is unstalled.
- Undefined: single register stage as above.

Decomposition:
- Package mips_pkg: WORD_W=32 and REG_ADDR_W=5 constants, plus a typedef enum wb_sel_e {WB_ALU, WB_MEM, WB_PC4} for select encodings.
- Sub-module mux_nto1 (combinational, WIDTH/NUM_IN parameters, out-of-range → input 0, out-of-range flag output), instantiated once. The optional skid path reuses its output.

Test Plan:
- WIDTH=32, NUM_IN=4, out_ready=1; send in_data={32'hD,32'hC,32'hB,32'hA}, sel=2 → out_data=32'hC, out_valid=1 exactly one cycle after the accept.
- Back-to-back stream sel=0,1,2,3 with out_ready=1 → out_data A,B,C,D on consecutive cycles, in_ready stays 1.
- out_ready=0 for 3 cycles while out_valid=1 → out_data stable, in_ready=0 (no skid) or in_ready=1 for one accept then 0 (skid). Release → no loss, order preserved.
- NUM_IN=3, WIDTH=5, sel=3 → out_data=input 0 value 5'd7, sel_err=1 for exactly one cycle.
- flush together with in_valid=1 → out_valid=0 next cycle, word dropped. Following accept works normally.
- rst_n pulled low mid-stall → out_valid, out_data and sel_err go 0 immediately. First accept after release completes normally.
